// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU SEL codes, ALUOp codes, funct constants.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
// Contents: alu_sel_e, alu_op_e, FUNCT_* constants, ctrl_t, decode_sel().
package id_ex_stage_pkg;

    // ALU SEL codes driven straight onto the ALU.
    typedef enum logic [2:0] {
        SEL_ADD = 3'b000,
        SEL_SUB = 3'b001,
        SEL_AND = 3'b010,
        SEL_OR  = 3'b011,
        SEL_XOR = 3'b100,
        SEL_BAD = 3'b110,
        SEL_SLT = 3'b111
    } alu_sel_e;

    // ALUOp from the main decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    // R-type funct fields understood by the ALU.
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Registered control bundle; all-zero is a bubble.
    typedef struct packed {
        logic     alu_src;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     illegal;
        alu_sel_e sel;
    } ctrl_t;

    typedef struct packed {
        alu_sel_e sel;
        logic     illegal;
    } sel_dec_t;

    // ALUOp/funct -> SEL. Unknown R-type functs map to SEL_BAD and raise illegal.
    function automatic sel_dec_t decode_sel(input logic [1:0] alu_op, input logic [5:0] funct);
        sel_dec_t d;
        d.sel     = SEL_ADD;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: d.sel = SEL_ADD;
            ALUOP_SUB: d.sel = SEL_SUB;
            ALUOP_OR:  d.sel = SEL_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: d.sel = SEL_ADD;
                    FUNCT_SUB: d.sel = SEL_SUB;
                    FUNCT_AND: d.sel = SEL_AND;
                    FUNCT_OR:  d.sel = SEL_OR;
                    FUNCT_XOR: d.sel = SEL_XOR;
                    FUNCT_SLT: d.sel = SEL_SLT;
                    default: begin
                        d.sel     = SEL_BAD;
                        d.illegal = 1'b1;
                    end
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forwarding taps and EX-side outputs of the ID/EX stage.
// Latency: n/a (wires only).
// Backpressure: stall/flush travel from the hazard logic into the stage.
// Modports: master = decode/pipeline side (drives id_*, exm_*, wb_*, stall, flush);
//           slave  = id_ex_stage (drives alu_*, ex_*, load_use_hazard).
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [5:0]    id_funct;
    logic [1:0]    id_alu_op;
    logic          id_alu_src;
    logic          id_reg_dst;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          exm_reg_write;
    logic [RW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dst;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_illegal;
    logic          load_use_hazard;

    modport master (
        output stall, flush,
        output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct,
        output id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
        output id_mem_read, id_mem_write, id_mem_to_reg,
        output exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        input  alu_a, alu_b, alu_sel, ex_store_data, ex_dst,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        input  ex_illegal, load_use_hazard
    );

    modport slave (
        input  stall, flush,
        input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct,
        input  id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
        input  id_mem_read, id_mem_write, id_mem_to_reg,
        input  exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        output alu_a, alu_b, alu_sel, ex_store_data, ex_dst,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        output ex_illegal, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage_fwd.sv
// Operand forwarding mux for one ALU source path (rs or rt).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: src/reg_data = latched register number and value; exm_*/wb_* = later-stage
//        write-back taps; data = forwarded operand.
module id_ex_stage_fwd #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_data,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] data
);
    logic hit_exm;
    logic hit_wb;

    // $zero is hardwired, so a pending write to it must never be forwarded.
    assign hit_exm = exm_reg_write && (exm_rd != '0) && (exm_rd == src);
    assign hit_wb  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);

    // EX/MEM holds the younger result, so it takes priority over MEM/WB.
    always_comb begin
        data = reg_data;
        if (hit_exm) begin
            data = exm_result;
        end else if (hit_wb) begin
            data = wb_result;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU SEL decode, operand forwarding and load-use detection.
// Latency: 1 cycle from ID inputs to outputs; forwarding is combinational on latched state.
// Backpressure: stall holds all registers, flush (or rst) loads a bubble; flush beats stall.
// Ports: clk, rst (sync, active-high); bus = id_ex_stage_if.slave carrying ID inputs,
//        EX/MEM and MEM/WB forwarding taps, and the ALU/EX outputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    ctrl_t         ctrl_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [RW-1:0] dst_q;

    sel_dec_t      dec;
    ctrl_t         ctrl_d;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // SEL and destination are resolved in ID so EX sees settled values at the edge.
    always_comb begin
        dec               = decode_sel(bus.id_alu_op, bus.id_funct);
        ctrl_d            = '0;
        ctrl_d.alu_src    = bus.id_alu_src;
        ctrl_d.reg_write  = bus.id_reg_write;
        ctrl_d.mem_read   = bus.id_mem_read;
        ctrl_d.mem_write  = bus.id_mem_write;
        ctrl_d.mem_to_reg = bus.id_mem_to_reg;
        ctrl_d.illegal    = dec.illegal;
        ctrl_d.sel        = dec.sel;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
        end else if (!bus.stall) begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= bus.id_rs_data;
            rt_data_q <= bus.id_rt_data;
            imm_q     <= bus.id_imm;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            dst_q     <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

    id_ex_stage_fwd #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src           (rs_q),
        .reg_data      (rs_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .data          (fwd_a)
    );

    id_ex_stage_fwd #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src           (rt_q),
        .reg_data      (rt_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .data          (fwd_b)
    );

    assign bus.alu_a         = fwd_a;
    assign bus.alu_b         = ctrl_q.alu_src ? imm_q : fwd_b;
    assign bus.alu_sel       = ctrl_q.sel;
    // Stores always need the register value, even when B carries the offset.
    assign bus.ex_store_data = fwd_b;
    assign bus.ex_dst        = dst_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_illegal    = ctrl_q.illegal;

    // A load in EX cannot forward in time to the instruction currently in ID.
    assign bus.load_use_hazard = ctrl_q.mem_read && (dst_q != '0) &&
                                 ((dst_q == bus.id_rs) || (dst_q == bus.id_rt));
endmodule
